// File: rtl/text_console_writer.sv
// Byte-stream to text-area command generator: cursor, wrap, CR/LF, scroll and row clearing.
// Optional backspace handling is built when TEXT_CONSOLE_BACKSPACE_EN is defined.
module text_console_writer #(
  parameter int          COLS         = 80,
  parameter int          VIS_ROWS     = 60,
  parameter int          BUF_ROWS     = 64,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
) (
  input  logic        i_cmd_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic [7:0]  i_attr,
  input  logic        i_clear,
  output logic        o_busy,
  output logic [31:0] o_cmd_data,
  output logic [5:0]  o_cursor_row,
  output logic [6:0]  o_cursor_col
);

  localparam int RW = $clog2(BUF_ROWS);
  localparam logic [6:0]    LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]    LAST_ROW = 6'(VIS_ROWS - 1);
  localparam logic [RW-1:0] LAST_BUF = RW'(BUF_ROWS - 1);
  localparam logic [RW-1:0] VIS_OFF  = RW'(VIS_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    POS,
    CELL,
    NL,
    SCROLL,
    CLR_POS,
    CLR_CELL
  } state_t;

  state_t          state_reg;
  logic            phase_reg;
  logic [31:0]     cmd_reg;
  logic [5:0]      row_reg;
  logic [6:0]      col_reg;
  logic [RW-1:0]   top_reg;
  logic [7:0]      attr_reg;
  logic [7:0]      char_reg;
  logic            erase_reg;
  logic            clr_all_reg;
  logic [RW-1:0]   clr_row_reg;
  logic [6:0]      clr_col_reg;
  logic [RW-1:0]   abs_row;

  assign abs_row = top_reg + RW'(row_reg);

  function automatic logic [31:0] cursor_cmd(input logic [5:0] row, input logic [6:0] col);
    return {4'b0111, 6'd0, row, 9'd0, col};
  endfunction

  function automatic logic [31:0] cell_cmd(input logic [7:0] attr, input logic [7:0] ch);
    return {4'b1000, 12'd0, attr, ch};
  endfunction

  function automatic logic [31:0] scroll_cmd(input logic [RW-1:0] top);
    return {4'b0010, 19'd0, 6'(top), 3'b000};
  endfunction

  assign o_byte_ready = (state_reg == IDLE) && !i_clear;
  assign o_busy       = (state_reg != IDLE);
  assign o_cmd_data   = cmd_reg;
  assign o_cursor_row = row_reg;
  assign o_cursor_col = col_reg;

  always_ff @(posedge i_cmd_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      phase_reg   <= 1'b0;
      cmd_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      top_reg     <= '0;
      attr_reg    <= DEFAULT_ATTR;
      char_reg    <= '0;
      erase_reg   <= 1'b0;
      clr_all_reg <= 1'b0;
      clr_row_reg <= '0;
      clr_col_reg <= '0;
    end else begin
      phase_reg <= ~phase_reg;
      // Commands change only on the edge before the consumer's execute edge; idle slots carry NOP.
      if (phase_reg) cmd_reg <= '0;

      case (state_reg)
        IDLE: begin
          if (i_clear) begin
            top_reg     <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            clr_all_reg <= 1'b1;
            clr_row_reg <= '0;
            clr_col_reg <= '0;
            state_reg   <= SCROLL;
          end else if (i_byte_valid) begin
            attr_reg <= i_attr;
            if (i_byte >= 8'h20 && i_byte <= 8'h7E) begin
              char_reg  <= i_byte;
              erase_reg <= 1'b0;
              state_reg <= POS;
            end else if (i_byte == 8'h0D) begin
              col_reg <= '0;
            end else if (i_byte == 8'h0A) begin
              state_reg <= NL;
            end
`ifdef TEXT_CONSOLE_BACKSPACE_EN
            else if (i_byte == 8'h08 && col_reg != 7'd0) begin
              col_reg   <= col_reg - 7'd1;
              char_reg  <= 8'h20;
              erase_reg <= 1'b1;
              state_reg <= POS;
            end
`endif
          end
        end

        POS: begin
          if (phase_reg) begin
            cmd_reg   <= cursor_cmd(6'(abs_row), col_reg);
            state_reg <= CELL;
          end
        end

        CELL: begin
          if (phase_reg) begin
            cmd_reg <= cell_cmd(attr_reg, char_reg);
            if (erase_reg) begin
              state_reg <= IDLE;
            end else if (col_reg == LAST_COL) begin
              col_reg   <= '0;
              state_reg <= NL;
            end else begin
              col_reg   <= col_reg + 7'd1;
              state_reg <= IDLE;
            end
          end
        end

        NL: begin
          if (row_reg < LAST_ROW) begin
            row_reg   <= row_reg + 6'd1;
            state_reg <= IDLE;
          end else begin
            // New top row; the row entering at the bottom is top + VIS_ROWS - 1 of the new top.
            top_reg     <= top_reg + 1'b1;
            clr_row_reg <= top_reg + VIS_OFF;
            clr_col_reg <= '0;
            clr_all_reg <= 1'b0;
            state_reg   <= SCROLL;
          end
        end

        SCROLL: begin
          if (phase_reg) begin
            cmd_reg   <= scroll_cmd(top_reg);
            state_reg <= CLR_POS;
          end
        end

        CLR_POS: begin
          if (phase_reg) begin
            cmd_reg   <= cursor_cmd(6'(clr_row_reg), clr_col_reg);
            state_reg <= CLR_CELL;
          end
        end

        CLR_CELL: begin
          if (phase_reg) begin
            cmd_reg <= cell_cmd(attr_reg, 8'h20);
            if (clr_col_reg == LAST_COL) begin
              clr_col_reg <= '0;
              if (clr_all_reg && clr_row_reg != LAST_BUF) begin
                clr_row_reg <= clr_row_reg + 1'b1;
                state_reg   <= CLR_POS;
              end else begin
                clr_all_reg <= 1'b0;
                state_reg   <= IDLE;
              end
            end else begin
              clr_col_reg <= clr_col_reg + 7'd1;
              state_reg   <= CLR_POS;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Randomised bench for text_console_writer against a queue-based console model.
module tb_text_console_writer;
  localparam int COLS     = 80;
  localparam int VIS_ROWS = 60;
  localparam int BUF_ROWS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  attr_in = '0;
  logic        clear = 1'b0;
  logic        busy;
  logic [31:0] cmd_data;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;

  always #5 clk = ~clk;

  text_console_writer #(
    .COLS(COLS), .VIS_ROWS(VIS_ROWS), .BUF_ROWS(BUF_ROWS), .DEFAULT_ATTR(8'h0F)
  ) dut (
    .i_cmd_clk(clk), .i_rst(rst), .i_byte(byte_in), .i_byte_valid(byte_valid),
    .o_byte_ready(byte_ready), .i_attr(attr_in), .i_clear(clear), .o_busy(busy),
    .o_cmd_data(cmd_data), .o_cursor_row(cur_row), .o_cursor_col(cur_col)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slot monitor: commands are captured once per slot, after the edge that loads them.
  int unsigned edge_n = 0;
  logic [31:0] last_slot = '0;
  logic [31:0] got_q[$];

  always @(posedge clk) begin
    if (rst) edge_n = 0;
    else     edge_n = edge_n + 1;
  end

  always @(negedge clk) begin
    if (!rst && edge_n > 0) begin
      if (edge_n % 2 == 0) begin
        last_slot = cmd_data;
        if (cmd_data != 32'd0) got_q.push_back(cmd_data);
      end else if (edge_n > 1 && last_slot != 32'd0) begin
        check("slot_hold", cmd_data, last_slot);
      end
    end
  end

  // Console model
  int          m_row, m_col, m_top;
  logic [7:0]  m_attr;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] enc_cursor(input int r, input int c);
    return 32'h7000_0000 | (32'(r) << 16) | 32'(c);
  endfunction
  function automatic logic [31:0] enc_cell(input logic [7:0] a, input logic [7:0] ch);
    return 32'h8000_0000 | (32'(a) << 8) | 32'(ch);
  endfunction
  function automatic logic [31:0] enc_scroll(input int t);
    return 32'h2000_0000 | 32'(t * 8);
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_top = 0; m_attr = 8'h0F;
    exp_q.delete();
  endtask

  task automatic clear_row(input int r);
    for (int c = 0; c < COLS; c++) begin
      exp_q.push_back(enc_cursor(r, c));
      exp_q.push_back(enc_cell(m_attr, 8'h20));
    end
  endtask

  task automatic model_newline();
    if (m_row < VIS_ROWS - 1) begin
      m_row++;
    end else begin
      m_top = (m_top + 1) % BUF_ROWS;
      exp_q.push_back(enc_scroll(m_top));
      clear_row((m_top + VIS_ROWS - 1) % BUF_ROWS);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [7:0] a);
    m_attr = a;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(enc_cursor((m_top + m_row) % BUF_ROWS, m_col));
      exp_q.push_back(enc_cell(a, b));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        model_newline();
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      model_newline();
    end
`ifdef TEXT_CONSOLE_BACKSPACE_EN
    else if (b == 8'h08 && m_col > 0) begin
      m_col--;
      exp_q.push_back(enc_cursor((m_top + m_row) % BUF_ROWS, m_col));
      exp_q.push_back(enc_cell(a, 8'h20));
    end
`endif
  endtask

  task automatic model_clear();
    m_top = 0; m_row = 0; m_col = 0;
    exp_q.push_back(enc_scroll(0));
    for (int r = 0; r < BUF_ROWS; r++) clear_row(r);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] a);
    int t = 0;
    while (!byte_ready && t < 40000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40000) check("ready_timeout", 32'd0, 32'd1);
    byte_in = b;
    attr_in = a;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 byte_valid = 1'b0;
    model_byte(b, a);
    $display("byte %02h attr %02h -> row %0d col %0d top %0d", b, a, m_row, m_col, m_top);
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (3) @(negedge clk);
    while (busy && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30000) check("idle_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check({tag, "_row"}, 32'(cur_row), 32'(m_row));
    check({tag, "_col"}, 32'(cur_col), 32'(m_col));
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 70)      return 8'($urandom_range(32, 126));
    else if (r < 78) return 8'h0A;
    else if (r < 84) return 8'h0D;
    else if (r < 92) return 8'h08;
    else if (r < 96) return 8'($urandom_range(0, 31));
    else             return 8'($urandom_range(127, 255));
  endfunction

  task automatic random_batch(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      send_byte(rand_byte(), 8'($urandom));
      wait_idle();
      compare(tag);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd", cmd_data, 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_col", 32'(cur_col), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_cmd", cmd_data, 32'd0);
      check("idle_ready", 32'(byte_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
    end

    send_byte(8'h41, 8'h1E);
    wait_idle();
    check("first_n", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("first_cursor", got_q[0], 32'h7000_0000);
      check("first_cell", got_q[1], 32'h8000_1E41);
    end
    check("first_col", 32'(cur_col), 32'd1);
    compare("first");

    send_byte(8'h0D, 8'h1E);
    repeat (5) send_byte(8'h0A, 8'h1E);
    repeat (79) send_byte(8'($urandom_range(32, 126)), 8'($urandom));
    send_byte(8'h5A, 8'h3C);
    wait_idle();
    if (got_q.size() >= 2) begin
      check("wrap_cursor", got_q[got_q.size() - 2], 32'h7005_004F);
      check("wrap_cell", got_q[got_q.size() - 1], 32'h8000_3C5A);
    end
    check("wrap_row", 32'(cur_row), 32'd6);
    check("wrap_col", 32'(cur_col), 32'd0);
    compare("wrap");

    random_batch(80, "rnd1");

    // Clear together with a valid byte: the byte must be refused.
    @(negedge clk);
    byte_in = 8'h55; attr_in = 8'hAA; byte_valid = 1'b1; clear = 1'b1;
    #1 check("clr_ready", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0; byte_valid = 1'b0;
    model_clear();
    wait_idle();
    if (got_q.size() >= 1) check("clr_scroll", got_q[0], 32'h2000_0000);
    compare("clr");

    repeat (59) send_byte(8'h0A, 8'h21);
    wait_idle();
    compare("lf59");
    send_byte(8'h0A, 8'h21);
    wait_idle();
    if (got_q.size() >= 2) begin
      check("scr_cmd", got_q[0], 32'h2000_0008);
      check("scr_row60", got_q[1], 32'h703C_0000);
    end
    compare("scr1");

    repeat (62) send_byte(8'h0A, 8'h47);
    wait_idle();
    compare("scr62");
    send_byte(8'h0A, 8'h47);
    wait_idle();
    if (got_q.size() >= 2) begin
      check("topwrap_cmd", got_q[0], 32'h2000_0000);
      check("topwrap_row59", got_q[1], 32'h703B_0000);
    end
    compare("topwrap");

    random_batch(60, "rnd2");

    // Reset in the middle of a full clear.
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (1000) @(negedge clk);
    check("midclr_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_cmd", cmd_data, 32'd0);
    check("midrst_row", 32'(cur_row), 32'd0);
    check("midrst_col", 32'(cur_col), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_cmd", cmd_data, 32'd0);
      check("postrst_ready", 32'(byte_ready), 32'd1);
    end

    random_batch(40, "rnd3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
